// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types for the training sequencer: FSM state encoding and the signed fixed-point (Q8.8) helpers.
// All sfp arithmetic saturates to the representable range instead of wrapping.
package mlp_train_sequencer_pkg;

    localparam int SFP_W    = 16;
    localparam int SFP_FRAC = 8;

    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp ONE     = sfp'(1 << SFP_FRAC);
    localparam sfp SFP_MAX = sfp'(16'h7fff);
    localparam sfp SFP_MIN = sfp'(16'h8000);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FETCH,
        SETTLE,
        UPDATE,
        NEXT,
        DONE
    } train_seq_state;

    function automatic sfp sfp_sat(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return SFP_MAX;
        end else if (v < -32'sd32768) begin
            return SFP_MIN;
        end
        return sfp'(v);
    endfunction

    function automatic sfp sfp_add(input sfp a, input sfp b);
        return sfp_sat(32'(a) + 32'(b));
    endfunction

    function automatic sfp sfp_sub(input sfp a, input sfp b);
        return sfp_sat(32'(a) - 32'(b));
    endfunction

    // Full-precision product fits in 32 bits; drop the extra fraction bits before saturating.
    function automatic sfp sfp_mul(input sfp a, input sfp b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b);
        return sfp_sat(p >>> SFP_FRAC);
    endfunction

endpackage

// File: rtl/mlp_train_sequencer_loss_accum.sv
// Squared-error accumulator for one epoch; publishes the sum to epoch_loss and restarts from zero.
// Only built when MLP_SEQ_LOSS_EN is defined.
`ifdef MLP_SEQ_LOSS_EN
module mlp_loss_accum
    import mlp_train_sequencer_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic add_i,
    input  logic pub_i,
    input  sfp   prediction_i,
    input  sfp   target_i,
    output sfp   epoch_loss_o
);

    sfp acc_q, acc_d;
    sfp loss_q, loss_d;
    sfp err;

    always_comb begin
        err    = sfp_sub(prediction_i, target_i);
        acc_d  = acc_q;
        loss_d = loss_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (pub_i) begin
            loss_d = acc_q;
            acc_d  = '0;
        end else if (add_i) begin
            acc_d = sfp_add(acc_q, sfp_mul(err, err));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            loss_q <= '0;
        end else begin
            acc_q  <= acc_d;
            loss_q <= loss_d;
        end
    end

    assign epoch_loss_o = loss_q;

endmodule
`endif

// File: rtl/mlp_train_sequencer.sv
// Training-run sequencer: init pulse, then per sample fetch / settle / one-cycle train_en, over all epochs.
// Define MLP_SEQ_LOSS_EN to accumulate per-epoch squared error into epoch_loss_o.
module mlp_train_sequencer
    import mlp_train_sequencer_pkg::*;
#(
    parameter int IDX_W    = 8,
    parameter int EP_W     = 16,
    parameter int SETTLE_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [IDX_W-1:0]    num_samples_i,
    input  logic [EP_W-1:0]     num_epochs_i,
    input  logic [SETTLE_W-1:0] settle_cycles_i,
    output logic                sample_req_o,
    output logic [IDX_W-1:0]    sample_addr_o,
    input  logic                sample_ack_i,
    output logic                net_init_o,
    output logic                train_en_o,
    input  sfp                  prediction_i,
    input  sfp                  target_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [EP_W-1:0]     epoch_o,
    output sfp                  epoch_loss_o,
    output logic                loss_valid_o
);

    train_seq_state state_q, state_d;

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [EP_W-1:0]     epoch_q, epoch_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]    ns_q, ns_d;
    logic [EP_W-1:0]     ne_q, ne_d;
    logic [SETTLE_W-1:0] st_q, st_d;

    logic last_sample;
    logic last_epoch;

    assign last_sample = (idx_q == ns_q - IDX_W'(1));
    assign last_epoch  = (epoch_q == ne_q - EP_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q   <= '0;
            epoch_q <= '0;
            cnt_q   <= '0;
            ns_q    <= '0;
            ne_q    <= '0;
            st_q    <= '0;
        end else begin
            idx_q   <= idx_d;
            epoch_q <= epoch_d;
            cnt_q   <= cnt_d;
            ns_q    <= ns_d;
            ne_q    <= ne_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        epoch_d = epoch_q;
        cnt_d   = cnt_q;
        ns_d    = ns_q;
        ne_d    = ne_q;
        st_d    = st_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        ns_d = num_samples_i;
                        ne_d = num_epochs_i;
                        st_d = settle_cycles_i;
                        if (num_samples_i == '0 || num_epochs_i == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = INIT;
                        end
                    end
                end
                INIT: begin
                    idx_d   = '0;
                    epoch_d = '0;
                    state_d = FETCH;
                end
                FETCH: begin
                    if (sample_ack_i) begin
                        if (st_q != '0) begin
                            cnt_d   = st_q;
                            state_d = SETTLE;
                        end else begin
                            state_d = UPDATE;
                        end
                    end
                end
                // cnt_q is loaded with settle_cycles on entry, so leaving at 1 gives exactly that many cycles here.
                SETTLE: begin
                    if (cnt_q <= SETTLE_W'(1)) begin
                        state_d = UPDATE;
                    end else begin
                        cnt_d = cnt_q - SETTLE_W'(1);
                    end
                end
                UPDATE: state_d = NEXT;
                NEXT: begin
                    if (last_sample) begin
                        idx_d = '0;
                        if (last_epoch) begin
                            state_d = DONE;
                        end else begin
                            epoch_d = epoch_q + EP_W'(1);
                            state_d = FETCH;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are gated by abort in the same cycle so no partial action reaches the layers.
    always_comb begin
        sample_req_o = 1'b0;
        net_init_o   = 1'b0;
        train_en_o   = 1'b0;
        done_o       = 1'b0;
        if (!abort_i) begin
            case (state_q)
                INIT:    net_init_o   = 1'b1;
                FETCH:   sample_req_o = 1'b1;
                UPDATE:  train_en_o   = 1'b1;
                DONE:    done_o       = 1'b1;
                default: ;
            endcase
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign sample_addr_o = idx_q;
    assign epoch_o       = epoch_q;

`ifdef MLP_SEQ_LOSS_EN
    logic loss_pub;

    assign loss_pub     = (state_q == NEXT) && last_sample && !abort_i;
    assign loss_valid_o = loss_pub;

    mlp_loss_accum u_loss_accum (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        ((state_q == INIT) || abort_i),
        .add_i        ((state_q == UPDATE) && !abort_i),
        .pub_i        (loss_pub),
        .prediction_i (prediction_i),
        .target_i     (target_i),
        .epoch_loss_o (epoch_loss_o)
    );
`else
    logic unused_loss_inputs;

    assign unused_loss_inputs = ^{prediction_i, target_i, last_sample};
    assign epoch_loss_o       = '0;
    assign loss_valid_o       = 1'b0;
`endif

endmodule
